// File: rtl/flags_pkg.sv
// -----------------------------------------------------------------------------
// flags_pkg
// Shared types and constants for the NZCV condition-flag producer.
//   flags_t      : packed {neg, zero, carry, overflow}, MSB first, which is the
//                  same bit order as the Flags bus {N,Z,C,V}.
//   FLAGW_NZ/CV  : bit indices into the two-bit FlagW group-enable vector.
//   FLAGS_RESET  : value loaded into every flag register on reset.
//   merge_flags  : per-group merge of freshly generated flags into held flags.
// -----------------------------------------------------------------------------
package flags_pkg;

  typedef struct packed {
    logic neg;
    logic zero;
    logic carry;
    logic overflow;
  } flags_t;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

  localparam flags_t FLAGS_RESET = 4'b0000;

  // N,Z travel together and C,V travel together; a group that is not
  // enabled keeps its currently held value.
  function automatic flags_t merge_flags(input flags_t cur,
                                         input flags_t gen,
                                         input logic   wr_nz,
                                         input logic   wr_cv);
    flags_t res;
    res = cur;
    if (wr_nz) begin
      res.neg  = gen.neg;
      res.zero = gen.zero;
    end else begin
      res.neg  = cur.neg;
      res.zero = cur.zero;
    end
    if (wr_cv) begin
      res.carry    = gen.carry;
      res.overflow = gen.overflow;
    end else begin
      res.carry    = cur.carry;
      res.overflow = cur.overflow;
    end
    return res;
  endfunction

endpackage

// File: rtl/flag_gen.sv
// -----------------------------------------------------------------------------
// flag_gen
// Purely combinational derivation of candidate NZCV flags from an ALU result.
// Ports:
//   alu_result_i   [WIDTH-1:0]  result of the current instruction
//   alu_carry_i                 ALU carry-out / shifter carry
//   alu_overflow_i              ALU signed overflow
//   gen_flags_o    flags_t      {N,Z,C,V} derived from the inputs
// -----------------------------------------------------------------------------
module flag_gen
  import flags_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_carry_i,
  input  logic             alu_overflow_i,
  output flags_t           gen_flags_o
);

  assign gen_flags_o.neg      = alu_result_i[WIDTH-1];
  assign gen_flags_o.zero     = (alu_result_i == {WIDTH{1'b0}});
  assign gen_flags_o.carry    = alu_carry_i;
  assign gen_flags_o.overflow = alu_overflow_i;

endmodule

// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit
// Architectural NZCV flags register with a one-entry saved copy.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   ALUResult      [WIDTH-1:0] result used to derive N and Z
//   ALUCarry       carry used for C
//   ALUOverflow    overflow used for V
//   FlagW          [1:0] group enables, bit1 = N,Z ; bit0 = C,V
//   CondEx         condition-passed; low blocks every ALU-driven update
//   FlagLoad       direct load of FlagLoadData (ungated by CondEx)
//   FlagLoadData   [3:0] {N,Z,C,V} for FlagLoad
//   FlagSave       copy the current (pre-update) flags into SavedFlags
//   FlagRestore    copy SavedFlags into the flags register
//   Flags          [3:0] registered flags {N,Z,C,V}
//   FlagsNext      [3:0] value Flags takes at the next edge (forwarding path)
//   SavedFlags     [3:0] registered saved flags
//   FlagsChanged   registered, high for one cycle after Flags changed value
// Next-value priority: restore > load > ALU group merge > hold.
// Save and restore together swap the two registers.
// -----------------------------------------------------------------------------
module flag_unit
  import flags_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             ALUCarry,
  input  logic             ALUOverflow,
  input  logic [1:0]       FlagW,
  input  logic             CondEx,
  input  logic             FlagLoad,
  input  logic [3:0]       FlagLoadData,
  input  logic             FlagSave,
  input  logic             FlagRestore,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsNext,
  output logic [3:0]       SavedFlags,
  output logic             FlagsChanged
);

  flags_t gen_flags_s;
  flags_t flags_q, flags_d;
  flags_t saved_q, saved_d;
  logic   changed_q, changed_d;
  logic   wr_nz_s, wr_cv_s;

  flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .alu_result_i   (ALUResult),
    .alu_carry_i    (ALUCarry),
    .alu_overflow_i (ALUOverflow),
    .gen_flags_o    (gen_flags_s)
  );

  assign wr_nz_s = FlagW[FLAGW_NZ] & CondEx;
  assign wr_cv_s = FlagW[FLAGW_CV] & CondEx;

  // Next flags value, saved value and change indication.
  always_comb begin
    flags_d   = flags_q;
    saved_d   = saved_q;
    changed_d = 1'b0;

    if (FlagRestore) begin
      flags_d = saved_q;
    end else if (FlagLoad) begin
      flags_d = flags_t'(FlagLoadData);
    end else if (wr_nz_s || wr_cv_s) begin
      flags_d = merge_flags(flags_q, gen_flags_s, wr_nz_s, wr_cv_s);
    end else begin
      flags_d = flags_q;
    end

    // Save always captures the pre-update flags, which also makes
    // save+restore a swap.
    if (FlagSave) begin
      saved_d = flags_q;
    end else begin
      saved_d = saved_q;
    end

    changed_d = (flags_d != flags_q);
  end

  // Flag, saved-flag and change registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q   <= FLAGS_RESET;
      saved_q   <= FLAGS_RESET;
      changed_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      saved_q   <= saved_d;
      changed_q <= changed_d;
    end
  end

  assign Flags        = flags_q;
  assign FlagsNext    = flags_d;
  assign SavedFlags   = saved_q;
  assign FlagsChanged = changed_q;

endmodule
